// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response sequencer.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_CMD,
    GET_DATA,
    GET_CHK,
    EXEC,
    TX_SYNC,
    TX_STAT,
    TX_DATA,
    TX_CHK
  } state_t;

  localparam logic [7:0] SYNC_CMD_DEF = 8'hA5;
  localparam logic [7:0] SYNC_RSP_DEF = 8'h5A;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BADCHK  = 8'h01;
  localparam logic [7:0] STAT_BADADDR = 8'h02;

  // Frame checksum: plain XOR of the three leading bytes.
  function automatic logic [7:0] chk3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_tx_seq.sv
// Four-byte response sender: captures the frame on start, then hands the
// bytes to the UART transmitter one at a time using its dv/done handshake.
module uart_tx_seq (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0][7:0] rsp_bytes,   // element 0 goes out first
  input  logic            tx_active,
  input  logic            tx_done,
  output logic            tx_dv,
  output logic [7:0]      tx_byte,
  output logic            byte_done,
  output logic            finished
);

  logic [3:0][7:0] frame_q;
  logic [1:0]      idx_q;
  logic            running_q;
  logic            pend_q;

  // A done pulse only counts while one of our bytes is on the wire, so a
  // late done from a transfer cut short by reset is ignored.
  assign byte_done = pend_q & tx_done;
  assign finished  = byte_done & (idx_q == 2'd3);

  // Issue a byte only when the transmitter is idle and nothing is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dv     <= 1'b0;
      tx_byte   <= 8'h00;
      idx_q     <= 2'd0;
      running_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      tx_dv <= 1'b0;
      if (start) begin
        running_q <= 1'b1;
        idx_q     <= 2'd0;
        pend_q    <= 1'b0;
      end else if (running_q) begin
        if (pend_q) begin
          if (tx_done) begin
            pend_q <= 1'b0;
            if (idx_q == 2'd3) running_q <= 1'b0;
            else               idx_q     <= idx_q + 2'd1;
          end
        end else if (!tx_active) begin
          tx_dv   <= 1'b1;
          tx_byte <= frame_q[idx_q];
          pend_q  <= 1'b1;
        end
      end
    end
  end

  // Response bytes are plain data captured once per frame.
  always_ff @(posedge clk) begin
    if (start) frame_q <= rsp_bytes;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command frame parser and register access sequencer sitting between the
// UART RX/TX byte interfaces and the robot register bank.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         ADDR_W       = 4,
  parameter int         NUM_REGS     = 12,
  parameter int         TIMEOUT_CLKS = 3900,
  parameter logic [7:0] SYNC_CMD     = SYNC_CMD_DEF,
  parameter logic [7:0] SYNC_RSP     = SYNC_RSP_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_dv,
  input  logic [7:0]        i_rx_byte,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              o_reg_wr,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy,
  output logic              o_err_pulse
);

  localparam int                TOUT_W     = $clog2(TIMEOUT_CLKS);
  localparam logic [TOUT_W-1:0] TOUT_LAST  = TOUT_W'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, data_q, chk_q;
  logic [TOUT_W-1:0] tout_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              in_get, tout_hit, chk_ok, addr_ok;
  logic [7:0]        stat, rdata;
  logic              rsp_start;
  logic [3:0][7:0]   rsp_bytes;
  logic              byte_done, finished;

  assign in_get   = (state_q == GET_CMD) || (state_q == GET_DATA) || (state_q == GET_CHK);
  // An arriving byte takes precedence over the terminal count.
  assign tout_hit = in_get && !i_rx_dv && (tout_q == TOUT_LAST);
  assign chk_ok   = (chk3(SYNC_CMD, cmd_q, data_q) == chk_q);
  assign addr_ok  = ({1'b0, cmd_q[ADDR_W-1:0]} < NUM_REGS_L);
  assign o_busy   = (state_q != IDLE);

  // The bank sees the live command during EXEC and the last one otherwise.
  assign o_reg_addr  = (state_q == EXEC) ? cmd_q[ADDR_W-1:0] : addr_q;
  assign o_reg_wdata = (state_q == EXEC) ? data_q : wdata_q;

  assign rsp_bytes = {chk3(SYNC_RSP, stat, rdata), rdata, stat, SYNC_RSP};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Inter-byte timeout counter, live only while collecting a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          tout_q <= '0;
    else if (!in_get || i_rx_dv || tout_hit) tout_q <= '0;
    else                                   tout_q <= tout_q + 1'b1;
  end

  // Frame byte capture; pure data, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_rx_dv) begin
      case (state_q)
        GET_CMD:  cmd_q  <= i_rx_byte;
        GET_DATA: data_q <= i_rx_byte;
        GET_CHK:  chk_q  <= i_rx_byte;
        default:  ;
      endcase
    end
  end

  // Hold the register bus values from the most recent EXEC.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= 8'h00;
    end else if (state_q == EXEC) begin
      addr_q  <= cmd_q[ADDR_W-1:0];
      wdata_q <= data_q;
    end
  end

  // Next-state, register strobe, status and error decisions.
  always_comb begin
    state_d     = state_q;
    rsp_start   = 1'b0;
    o_reg_wr    = 1'b0;
    o_err_pulse = 1'b0;
    stat        = STAT_OK;
    rdata       = 8'h00;
    case (state_q)
      IDLE: if (i_rx_dv && (i_rx_byte == SYNC_CMD)) state_d = GET_CMD;
      GET_CMD: begin
        if (i_rx_dv)       state_d = GET_DATA;
        else if (tout_hit) begin state_d = IDLE; o_err_pulse = 1'b1; end
      end
      GET_DATA: begin
        if (i_rx_dv)       state_d = GET_CHK;
        else if (tout_hit) begin state_d = IDLE; o_err_pulse = 1'b1; end
      end
      GET_CHK: begin
        if (i_rx_dv)       state_d = EXEC;
        else if (tout_hit) begin state_d = IDLE; o_err_pulse = 1'b1; end
      end
      EXEC: begin
        rsp_start = 1'b1;
        state_d   = TX_SYNC;
        if (!chk_ok) begin
          stat        = STAT_BADCHK;
          o_err_pulse = 1'b1;
        end else if (!addr_ok) begin
          stat        = STAT_BADADDR;
          o_err_pulse = 1'b1;
        end else if (cmd_q[7]) begin
          o_reg_wr = 1'b1;
          rdata    = data_q;
        end else begin
          rdata = i_reg_rdata;
        end
      end
      TX_SYNC: if (byte_done) state_d = TX_STAT;
      TX_STAT: if (byte_done) state_d = TX_DATA;
      TX_DATA: if (byte_done) state_d = TX_CHK;
      TX_CHK:  if (finished)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The parser does not buffer: bytes arriving mid-response are lost.
    if (i_rx_dv && (state_q inside {EXEC, TX_SYNC, TX_STAT, TX_DATA, TX_CHK}))
      o_err_pulse = 1'b1;
  end

  uart_tx_seq u_tx_seq (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .start     (rsp_start),
    .rsp_bytes (rsp_bytes),
    .tx_active (i_tx_active),
    .tx_done   (i_tx_done),
    .tx_dv     (o_tx_dv),
    .tx_byte   (o_tx_byte),
    .byte_done (byte_done),
    .finished  (finished)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a scoreboard of expected TX bytes
// and register writes, a small transmitter model and a register bank model.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic       reg_wr;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int dv_cnt = 0;

  logic [7:0]  regs [16];
  logic [7:0]  exp_tx [$];
  logic [11:0] exp_wr [$];

  logic hold_active = 1'b0;
  logic tx_busy = 1'b0;
  logic tx_go = 1'b0;
  int   tx_cnt = 0;

  always #5 clk = ~clk;

  assign reg_rdata = regs[reg_addr];
  assign tx_active = tx_busy | hold_active;

  uart_cmd_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_dv     (rx_dv),
    .i_rx_byte   (rx_byte),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .i_tx_active (tx_active),
    .i_tx_done   (tx_done),
    .o_reg_wr    (reg_wr),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .i_reg_rdata (reg_rdata),
    .o_busy      (busy),
    .o_err_pulse (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: goes busy the cycle after dv, done pulse after a few clocks.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (tx_busy) begin
        if (tx_cnt == 0) begin tx_busy = 1'b0; tx_done = 1'b1; end
        else tx_cnt--;
      end
      if (tx_go) begin tx_busy = 1'b1; tx_cnt = 5; tx_go = 1'b0; end
      if (tx_dv === 1'b1) tx_go = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every TX byte and register write.
  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [11:0] ew;
    if (rst_n) begin
      if (err === 1'b1) err_cnt++;
      if (tx_dv === 1'b1) begin
        dv_cnt++;
        check("tx_dv_while_active", tx_active, 0);
        check("tx_expected", (exp_tx.size() > 0), 1);
        if (exp_tx.size() > 0) begin
          eb = exp_tx.pop_front();
          check("tx_byte", tx_byte, eb);
        end
      end
      if (reg_wr === 1'b1) begin
        check("wr_expected", (exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          ew = exp_wr.pop_front();
          check("wr_addr_data", {reg_addr, reg_wdata}, ew);
        end
        regs[reg_addr] = reg_wdata;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic expect_tx(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    exp_tx.push_back(b0);
    exp_tx.push_back(b1);
    exp_tx.push_back(b2);
    exp_tx.push_back(b3);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_idle"}, (n < limit), 1);
    check({tag, "_tx_left"}, exp_tx.size(), 0);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
  endtask

  task automatic wait_dv(input string tag, input int base, input int want);
    int n = 0;
    while ((dv_cnt - base) < want && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_dv_seen"}, (n < 300), 1);
  endtask

  initial begin
    int e0;
    int d0;
    int n;
    for (int i = 0; i < 16; i++) regs[i] = 8'(i * 3 + 1);
    regs[5] = 8'h7E;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write 3C to register 3
    e0 = err_cnt;
    exp_wr.push_back({4'h3, 8'h3C});
    expect_tx(8'h5A, 8'h00, 8'h3C, 8'h66);
    send_frame(8'hA5, 8'h83, 8'h3C, 8'h1A);
    wait_idle("write", 300);
    check("write_err", err_cnt - e0, 0);
    check("write_reg3", regs[3], 8'h3C);
    check("write_addr_hold", reg_addr, 4'h3);

    // Read register 5
    e0 = err_cnt;
    expect_tx(8'h5A, 8'h00, 8'h7E, 8'h24);
    send_frame(8'hA5, 8'h05, 8'h00, 8'hA0);
    wait_idle("read", 300);
    check("read_err", err_cnt - e0, 0);

    // Read back register 3
    expect_tx(8'h5A, 8'h00, 8'h3C, 8'h66);
    send_frame(8'hA5, 8'h03, 8'h00, 8'hA6);
    wait_idle("readback", 300);

    // Bad checksum
    e0 = err_cnt;
    expect_tx(8'h5A, 8'h01, 8'h00, 8'h5B);
    send_frame(8'hA5, 8'h83, 8'h3C, 8'h00);
    wait_idle("badchk", 300);
    check("badchk_err", err_cnt - e0, 1);

    // Bad address
    e0 = err_cnt;
    expect_tx(8'h5A, 8'h02, 8'h00, 8'h58);
    send_frame(8'hA5, 8'h8E, 8'h11, 8'h3A);
    wait_idle("badaddr", 300);
    check("badaddr_err", err_cnt - e0, 1);
    check("badaddr_reg14", regs[14], 8'(14 * 3 + 1));

    // Junk byte in IDLE is silently discarded
    e0 = err_cnt;
    send_byte(8'h17);
    repeat (3) @(negedge clk);
    check("junk_busy", busy, 0);
    check("junk_err", err_cnt - e0, 0);

    // Timeout after CMD byte
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h83);
    n = 1;
    while (n <= 4100) begin
      @(negedge clk);
      if (err === 1'b1) break;
      n++;
    end
    check("tout_cycles", n, 3900);
    @(negedge clk);
    check("tout_busy", busy, 0);
    check("tout_err", err_cnt - e0, 1);

    // Normal frame after a timeout
    exp_wr.push_back({4'h1, 8'h55});
    expect_tx(8'h5A, 8'h00, 8'h55, 8'h0F);
    send_frame(8'hA5, 8'h81, 8'h55, 8'h71);
    wait_idle("post_tout", 300);

    // Byte landing on the terminal count wins
    e0 = err_cnt;
    exp_wr.push_back({4'h3, 8'h3C});
    expect_tx(8'h5A, 8'h00, 8'h3C, 8'h66);
    send_byte(8'hA5);
    repeat (3898) @(posedge clk);
    send_byte(8'h83);
    send_byte(8'h3C);
    send_byte(8'h1A);
    wait_idle("edge_tout", 300);
    check("edge_tout_err", err_cnt - e0, 0);

    // Byte arriving during the response is dropped with an error
    e0 = err_cnt;
    d0 = dv_cnt;
    expect_tx(8'h5A, 8'h00, 8'h7E, 8'h24);
    send_frame(8'hA5, 8'h05, 8'h00, 8'hA0);
    wait_dv("drop", d0, 1);
    send_byte(8'hA5);
    wait_idle("drop", 300);
    check("drop_err", err_cnt - e0, 1);

    // Transmitter backpressure
    hold_active = 1'b1;
    d0 = dv_cnt;
    expect_tx(8'h5A, 8'h00, 8'h7E, 8'h24);
    send_frame(8'hA5, 8'h05, 8'h00, 8'hA0);
    repeat (500) @(negedge clk);
    check("bp_no_dv", dv_cnt - d0, 0);
    check("bp_busy", busy, 1);
    @(posedge clk); #1;
    hold_active = 1'b0;
    wait_idle("bp", 300);
    check("bp_dv_count", dv_cnt - d0, 4);

    // Reset in the middle of a response
    d0 = dv_cnt;
    expect_tx(8'h5A, 8'h00, 8'h7E, 8'h24);
    send_frame(8'hA5, 8'h05, 8'h00, 8'hA0);
    wait_dv("midrst", d0, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_dv", tx_dv, 0);
    check("midrst_tx_byte", tx_byte, 0);
    check("midrst_busy", busy, 0);
    check("midrst_reg_addr", reg_addr, 0);
    check("midrst_reg_wdata", reg_wdata, 0);
    check("midrst_reg_wr", reg_wr, 0);
    check("midrst_err", err, 0);
    exp_tx.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = dv_cnt;
    e0 = err_cnt;
    repeat (30) @(negedge clk);
    check("stray_done_dv", dv_cnt - d0, 0);
    check("stray_done_busy", busy, 0);
    check("stray_done_err", err_cnt - e0, 0);

    // Recovery frame after reset
    exp_wr.push_back({4'h2, 8'hAA});
    expect_tx(8'h5A, 8'h00, 8'hAA, 8'hF0);
    send_frame(8'hA5, 8'h82, 8'hAA, 8'h8D);
    wait_idle("recover", 300);
    check("recover_reg2", regs[2], 8'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
